// File: rtl/mod_squared_acc_pkg.sv
// Shared radar-datapath definitions: default sample width, squared-width helper,
// S4 control states and the per-sample sideband carried down the power pipeline.
package mod_squared_acc_pkg;

  localparam int MODSQ_DATA_W = 16;
  localparam int MODSQ_CNT_W  = 8;

  function automatic int sq_w(input int data_w);
    return 2 * data_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DUMP  = 2'd2
  } s4_state_t;

  typedef struct packed {
    logic last;
    logic acc_en;
  } meta_t;

endpackage

// File: rtl/mod_sq_core.sv
// mod_sq_core: S1 input register, S2 signed squares, S3 sum -> exact unsigned |s|^2 plus sideband.
// Latency 3 cycles; every stage holds its contents while i_en is low.
module mod_sq_core
  import mod_squared_acc_pkg::*;
#(
  parameter int DATA_W = MODSQ_DATA_W,
  parameter int SB_W   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_vld,
  input  logic signed [DATA_W-1:0] i_i,
  input  logic signed [DATA_W-1:0] i_q,
  input  logic [SB_W-1:0]          i_sb,
  output logic                     o_vld,
  output logic [sq_w(DATA_W):0]    o_sum,
  output logic [SB_W-1:0]          o_sb
);

  localparam int SQ_W = sq_w(DATA_W);

  logic                     r_s1_vld;
  logic signed [DATA_W-1:0] r_s1_i;
  logic signed [DATA_W-1:0] r_s1_q;
  logic [SB_W-1:0]          r_s1_sb;

  logic                     r_s2_vld;
  logic [SQ_W-1:0]          r_s2_sq_i;
  logic [SQ_W-1:0]          r_s2_sq_q;
  logic [SB_W-1:0]          r_s2_sb;

  logic                     r_s3_vld;
  logic [SQ_W:0]            r_s3_sum;
  logic [SB_W-1:0]          r_s3_sb;

  logic signed [SQ_W-1:0]   w_i_ext;
  logic signed [SQ_W-1:0]   w_q_ext;
  logic signed [SQ_W-1:0]   w_sq_i;
  logic signed [SQ_W-1:0]   w_sq_q;

  // Squaring at full 2*DATA_W width keeps (-2^(DATA_W-1))^2 = 2^(2*DATA_W-2) exact.
  assign w_i_ext = {{DATA_W{r_s1_i[DATA_W-1]}}, r_s1_i};
  assign w_q_ext = {{DATA_W{r_s1_q[DATA_W-1]}}, r_s1_q};
  assign w_sq_i  = w_i_ext * w_i_ext;
  assign w_sq_q  = w_q_ext * w_q_ext;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_i    <= '0;
      r_s1_q    <= '0;
      r_s1_sb   <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_sq_i <= '0;
      r_s2_sq_q <= '0;
      r_s2_sb   <= '0;
      r_s3_vld  <= 1'b0;
      r_s3_sum  <= '0;
      r_s3_sb   <= '0;
    end else if (i_en) begin
      r_s1_vld  <= i_vld;
      r_s1_i    <= i_i;
      r_s1_q    <= i_q;
      r_s1_sb   <= i_sb;
      r_s2_vld  <= r_s1_vld;
      r_s2_sq_i <= w_sq_i;
      r_s2_sq_q <= w_sq_q;
      r_s2_sb   <= r_s1_sb;
      r_s3_vld  <= r_s2_vld;
      r_s3_sum  <= {1'b0, r_s2_sq_i} + {1'b0, r_s2_sq_q};
      r_s3_sb   <= r_s2_sb;
    end
  end

  assign o_vld = r_s3_vld;
  assign o_sum = r_s3_sum;
  assign o_sb  = r_s3_sb;

endmodule

// File: rtl/mod_squared_acc.sv
// mod_squared_acc: pipelined I^2+Q^2 with optional non-coherent integration; define MODSQ_SAT_EN to saturate.
// Latency 4 cycles accept->result; all stages stall while o_out_valid is held by !i_out_ready.
module mod_squared_acc
  import mod_squared_acc_pkg::*;
#(
  parameter int DATA_W = MODSQ_DATA_W,
  parameter int CNT_W  = MODSQ_CNT_W,
  parameter int ACC_W  = 2 * DATA_W + CNT_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic signed [DATA_W-1:0] i_in_i,
  input  logic signed [DATA_W-1:0] i_in_q,
  input  logic                     i_in_last,
  input  logic                     i_acc_en,
  input  logic [CNT_W-1:0]         i_acc_len,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [ACC_W-1:0]         o_out_data,
  output logic                     o_out_last,
  output logic                     o_out_ovf
);

  localparam int SUM_W = sq_w(DATA_W) + 1;
  localparam int ADD_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam int SB_W  = $bits(meta_t) + CNT_W;

  logic             w_en;
  meta_t            w_in_meta;
  logic [SB_W-1:0]  w_in_sb;
  logic             w_s3_vld;
  logic [SUM_W-1:0] w_s3_sum;
  logic [SB_W-1:0]  w_s3_sb;
  meta_t            w_s3_meta;
  logic [CNT_W-1:0] w_s3_len;

  s4_state_t        r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic             r_ovf;
  logic             r_out_vld;
  logic             r_out_last;

  logic             w_open;
  logic             w_close;
  logic             w_carry;
  logic [CNT_W-1:0] w_len_eff;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [ADD_W-1:0] w_add;
  logic [ACC_W-1:0] w_acc_nxt;

  assign w_en       = ~r_out_vld | i_out_ready;
  assign o_in_ready = w_en;

  // Frame controls ride with every sample; S4 only honours them on a frame's first sample.
  assign w_in_meta = '{last: i_in_last, acc_en: i_acc_en};
  assign w_in_sb   = {w_in_meta, i_acc_len};

  mod_sq_core #(
    .DATA_W (DATA_W),
    .SB_W   (SB_W)
  ) u_core (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_en),
    .i_vld (i_in_valid),
    .i_i   (i_in_i),
    .i_q   (i_in_q),
    .i_sb  (w_in_sb),
    .o_vld (w_s3_vld),
    .o_sum (w_s3_sum),
    .o_sb  (w_s3_sb)
  );

  assign {w_s3_meta, w_s3_len} = w_s3_sb;

  assign w_open    = (r_state == ACCUM);
  assign w_len_eff = (w_s3_len == '0) ? CNT_W'(1) : w_s3_len;
  assign w_cnt_nxt = w_open ? (r_cnt + CNT_W'(1)) : CNT_W'(1);
  assign w_add     = ADD_W'(w_open ? r_acc : '0) + ADD_W'(w_s3_sum);
  assign w_carry   = |w_add[ADD_W-1:ACC_W];

`ifdef MODSQ_SAT_EN
  assign w_acc_nxt = w_carry ? {ACC_W{1'b1}} : w_add[ACC_W-1:0];
`else
  assign w_acc_nxt = w_add[ACC_W-1:0];
`endif

  // An open frame is always integrating, so only its latched length and in_last can close it.
  assign w_close = w_open ? (w_s3_meta.last | (w_cnt_nxt == r_len))
                          : (~w_s3_meta.acc_en | w_s3_meta.last | (w_len_eff == CNT_W'(1)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_ovf      <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
    end else if (w_en) begin
      if (w_s3_vld) begin
        r_acc      <= w_acc_nxt;
        r_cnt      <= w_cnt_nxt;
        r_ovf      <= (w_open & r_ovf) | w_carry;
        if (!w_open) begin
          r_len <= w_len_eff;
        end
        r_state    <= w_close ? DUMP : ACCUM;
        r_out_vld  <= w_close;
        r_out_last <= w_close;
      end else if (r_state == DUMP) begin
        r_state    <= IDLE;
        r_out_vld  <= 1'b0;
        r_out_last <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_out_vld;
  assign o_out_data  = r_acc;
  assign o_out_last  = r_out_last;
  assign o_out_ovf   = r_ovf;

endmodule

// File: tb/tb_mod_squared_acc.sv
// Directed bench for mod_squared_acc: a default-width instance plus a narrow ACC_W=16 instance
// used for the wrap / saturate (MODSQ_SAT_EN) frames.
module tb_mod_squared_acc;

  localparam int DW    = 16;
  localparam int CW    = 8;
  localparam int AW    = 2 * DW + CW;
  localparam int SDW   = 8;
  localparam int SAW   = 16;
  localparam int LIMIT = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_last, acc_en, out_ready;
  logic [DW-1:0] in_i, in_q;
  logic [CW-1:0] acc_len;
  logic          in_ready, out_valid, out_last, out_ovf;
  logic [AW-1:0] out_data;

  logic           s_in_valid, s_in_last, s_acc_en, s_out_ready;
  logic [SDW-1:0] s_in_i, s_in_q;
  logic [CW-1:0]  s_acc_len;
  logic           s_in_ready, s_out_valid, s_out_last, s_out_ovf;
  logic [SAW-1:0] s_out_data;

  mod_squared_acc u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_i      (in_i),
    .i_in_q      (in_q),
    .i_in_last   (in_last),
    .i_acc_en    (acc_en),
    .i_acc_len   (acc_len),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_last  (out_last),
    .o_out_ovf   (out_ovf)
  );

  mod_squared_acc #(.DATA_W(SDW), .CNT_W(CW), .ACC_W(SAW)) u_small (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (s_in_valid),
    .o_in_ready  (s_in_ready),
    .i_in_i      (s_in_i),
    .i_in_q      (s_in_q),
    .i_in_last   (s_in_last),
    .i_acc_en    (s_acc_en),
    .i_acc_len   (s_acc_len),
    .o_out_valid (s_out_valid),
    .i_out_ready (s_out_ready),
    .o_out_data  (s_out_data),
    .o_out_last  (s_out_last),
    .o_out_ovf   (s_out_ovf)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_acc = 0;
  logic [63:0] q_data[$];
  logic        q_last[$];
  logic        q_ovf[$];
  int          q_cyc[$];
  int          stall_cnt = 0;
  int          stall_viol = 0;
  logic        m_stall = 1'b0;
  logic [AW-1:0] m_data = '0;
  logic        bp_on = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_on ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Handshakes seen at the falling edge complete on the following rising edge.
  initial forever begin
    @(negedge clk);
    if (m_stall) begin
      stall_cnt++;
      if (out_valid !== 1'b1 || out_data !== m_data) stall_viol++;
    end
    m_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
    m_data  = out_data;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      q_data.push_back(64'(out_data));
      q_last.push_back(out_last);
      q_ovf.push_back(out_ovf);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [DW-1:0] i, input logic [DW-1:0] q, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_i     = i;
    in_q     = q;
    in_last  = last;
    while (in_ready !== 1'b1 && guard < LIMIT) begin
      tick(1);
      guard++;
    end
    if (guard >= LIMIT) check("in_ready_timeout", 64'(in_ready), 64'd1);
    last_acc = cyc;
    tick(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (q_data.size() < n && k < LIMIT) begin
      tick(1);
      k++;
    end
    tick(8);
  endtask

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    q_ovf.delete();
    q_cyc.delete();
  endtask

  task automatic expect_one(input string tag, input logic [63:0] data, input logic ovf);
    drain(1);
    check({tag, "_count"}, 64'(q_data.size()), 64'd1);
    if (q_data.size() >= 1) begin
      check({tag, "_data"}, q_data[0], data);
      check({tag, "_last"}, 64'(q_last[0]), 64'd1);
      check({tag, "_ovf"}, 64'(q_ovf[0]), 64'(ovf));
      check({tag, "_lat"}, 64'(q_cyc[0] - last_acc), 64'd4);
    end
    clear_q();
  endtask

  task automatic s_send(input logic [SDW-1:0] i, input logic [SDW-1:0] q);
    s_in_valid = 1'b1;
    s_in_i     = i;
    s_in_q     = q;
    tick(1);
    s_in_valid = 1'b0;
  endtask

  task automatic s_expect(input string tag, input logic [63:0] data, input logic ovf);
    int k = 0;
    while (s_out_valid !== 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    check({tag, "_vld"}, 64'(s_out_valid), 64'd1);
    check({tag, "_data"}, 64'(s_out_data), data);
    check({tag, "_ovf"}, 64'(s_out_ovf), 64'(ovf));
    check({tag, "_last"}, 64'(s_out_last), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] ri, rq;
    longint        si, sq;
    logic [63:0]   exp_q[$];
    int            a_last, b_last;

    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; acc_en = 1'b0; acc_len = '0; in_i = '0; in_q = '0;
    s_in_valid = 1'b0; s_in_last = 1'b0; s_acc_en = 1'b0; s_acc_len = '0;
    s_in_i = '0; s_in_q = '0; s_out_ready = 1'b1;
    tick(3);
    rst = 1'b0;

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_s_out_valid", 64'(s_out_valid), 64'd0);
    check("rst_s_in_ready", 64'(s_in_ready), 64'd1);

    // Per-sample mode.
    acc_en = 1'b0;
    send(16'd3, 16'hFFFC, 1'b0);
    expect_one("single", 64'd25, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    expect_one("corner_min", 64'd2147483648, 1'b0);
    send(16'h7FFF, 16'h8000, 1'b0);
    expect_one("corner_mix", 64'd2147418113, 1'b0);
    send(16'd2, 16'd0, 1'b1);
    expect_one("last_noeffect", 64'd4, 1'b0);

    // Integration over 4 samples: 2 + 4 + 9 + 50.
    acc_en  = 1'b1;
    acc_len = 8'd4;
    send(16'd1, 16'd1, 1'b0);
    send(16'd2, 16'd0, 1'b0);
    send(16'd0, 16'hFFFD, 1'b0);
    send(16'd5, 16'd5, 1'b0);
    expect_one("integ4", 64'd65, 1'b0);

    acc_len = 8'd0;
    send(16'd2, 16'd3, 1'b0);
    expect_one("len_zero", 64'd13, 1'b0);

    // Early close via in_last, mid-frame acc_len change, then a back-to-back 2-sample frame.
    acc_len = 8'd8;
    send(16'd1, 16'd0, 1'b0);
    acc_len = 8'd2;
    send(16'd1, 16'd0, 1'b0);
    send(16'd1, 16'd0, 1'b1);
    a_last = last_acc;
    send(16'd2, 16'd0, 1'b0);
    send(16'd0, 16'd1, 1'b0);
    b_last = last_acc;
    drain(2);
    check("b2b_count", 64'(q_data.size()), 64'd2);
    check("b2b_no_bubble", 64'(b_last - a_last), 64'd2);
    if (q_data.size() >= 2) begin
      check("early_data", q_data[0], 64'd3);
      check("early_lat", 64'(q_cyc[0] - a_last), 64'd4);
      check("b2b_data", q_data[1], 64'd5);
      check("b2b_gap", 64'(q_cyc[1] - q_cyc[0]), 64'd2);
    end
    clear_q();

    // Backpressure: 100 per-sample results under ~30% out_ready.
    acc_en = 1'b0;
    bp_on  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      ri = DW'($urandom);
      rq = DW'($urandom);
      si = longint'($signed(ri));
      sq = longint'($signed(rq));
      exp_q.push_back(64'(si * si + sq * sq));
      send(ri, rq, 1'b0);
    end
    bp_on = 1'b0;
    drain(100);
    check("bp_count", 64'(q_data.size()), 64'd100);
    if (q_data.size() == 100) begin
      for (int k = 0; k < 100; k++) begin
        check($sformatf("bp_data_%0d", k), q_data[k], exp_q[k]);
      end
    end
    check("bp_stable", 64'(stall_viol), 64'd0);
    check("bp_stalled", 64'(stall_cnt > 0), 64'd1);
    clear_q();

    // Reset in the middle of an open frame.
    acc_en  = 1'b1;
    acc_len = 8'd4;
    send(16'd1, 16'd0, 1'b0);
    send(16'd1, 16'd0, 1'b0);
    tick(6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(8);
    check("rst_mid_count", 64'(q_data.size()), 64'd0);
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    acc_len = 8'd2;
    send(16'd3, 16'd0, 1'b0);
    send(16'd0, 16'd1, 1'b0);
    expect_one("after_rst", 64'd10, 1'b0);

    // Narrow accumulator: 4 x 32258 exceeds 16 bits.
    s_acc_en  = 1'b1;
    s_acc_len = 8'd4;
    repeat (4) s_send(8'd127, 8'd127);
`ifdef MODSQ_SAT_EN
    s_expect("ovf_frame", 64'd65535, 1'b1);
`else
    s_expect("ovf_frame", 64'd63496, 1'b1);
`endif
    s_acc_len = 8'd2;
    s_send(8'd1, 8'd1);
    s_send(8'd1, 8'd1);
    s_expect("ovf_cleared", 64'd4, 1'b0);
    s_acc_en = 1'b0;
    s_send(8'h80, 8'h80);
    s_expect("s_corner", 64'd32768, 1'b0);

    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
